// File: rtl/ofmap_writer_pkg.sv
// Shared definitions for the output feature-map writer and its neighbours
// (partial-sum buffer, output SRAM wrapper).
package ofmap_writer_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/ofmap_writer_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is only
// taken when a pop happens in the same cycle. Read data is zero while empty.
module sync_fifo
   import ofmap_writer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = DATA_W_DEF,
   localparam int AW   = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      level_o
);

   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   LVL_MAX = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             push_s, pop_s, full_s, empty_s;

   // Pointer and occupancy next-state; clear wins over any traffic.
   always_comb begin
      empty_s  = (level_q == {(AW + 1){1'b0}});
      full_s   = (level_q == LVL_MAX);
      pop_s    = pop_i & ~empty_s;
      push_s   = push_i & (~full_s | pop_s);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clr_i) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         level_d  = {(AW + 1){1'b0}};
      end else begin
         if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
         else        wr_ptr_d = wr_ptr_q;
         if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         else        rd_ptr_d = rd_ptr_q;
         case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {(AW + 1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are only observable through a valid head.
   always_ff @(posedge clk) begin
      if (push_s && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
   assign full_o  = full_s;
   assign empty_o = empty_s;
   assign level_o = level_q;

endmodule

// File: rtl/ofmap_writer.sv
// Drains pooled words from the partial-sum buffer into the output SRAM at
// sequential addresses, absorbing SRAM stalls and flagging lost words.
module ofmap_writer
   import ofmap_writer_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16,
   localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  total_words,
   input  logic              conv_valid,
   input  logic [DATA_W-1:0] conv_result,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic              sram_ready,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              excess,
   output logic [LVL_W-1:0]  fifo_level
);

   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  tot_q, tot_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
   logic [CNT_W-1:0]  in_inc_s, out_inc_s;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              overflow_q, overflow_d, excess_q, excess_d;
   logic              start_ok_s, in_room_s, take_s, hs_s, push_s;
   logic              fifo_full_s, fifo_empty_s;
   logic [DATA_W-1:0] fifo_rdata_s;
   logic [LVL_W-1:0]  fifo_level_s;

   // Every in-tile strobe counts toward the tile even if dropped, so a
   // full FIFO cannot stall the FSM in RUN.
   always_comb begin
      start_ok_s = start & (state_q == ST_IDLE);
      in_room_s  = (state_q == ST_RUN) & (in_cnt_q < tot_q);
      take_s     = conv_valid & in_room_s;
      hs_s       = ~fifo_empty_s & sram_ready;
      push_s     = take_s & (~fifo_full_s | hs_s);
      in_inc_s   = in_cnt_q + CNT_ONE;
      out_inc_s  = out_cnt_q + CNT_ONE;
      state_d    = state_q;
      tot_d      = tot_q;
      in_cnt_d   = in_cnt_q;
      out_cnt_d  = out_cnt_q;
      wr_addr_d  = wr_addr_q;
      overflow_d = overflow_q;
      excess_d   = excess_q;
      if (start_ok_s) begin
         tot_d      = total_words;
         wr_addr_d  = base_addr;
         in_cnt_d   = {CNT_W{1'b0}};
         out_cnt_d  = {CNT_W{1'b0}};
         overflow_d = 1'b0;
         excess_d   = 1'b0;
         state_d    = (total_words == {CNT_W{1'b0}}) ? ST_DONE : ST_RUN;
      end else begin
         if (take_s) in_cnt_d = in_inc_s;
         else        in_cnt_d = in_cnt_q;
         if (hs_s) begin
            out_cnt_d = out_inc_s;
            wr_addr_d = wr_addr_q + ADDR_ONE;
         end else begin
            out_cnt_d = out_cnt_q;
            wr_addr_d = wr_addr_q;
         end
         if (take_s && !push_s) overflow_d = 1'b1;
         else                   overflow_d = overflow_q;
         if (conv_valid && !in_room_s) excess_d = 1'b1;
         else                          excess_d = excess_q;
         // Dropped words never reach SRAM, so FLUSH also ends on drain+overflow.
         case (state_q)
            ST_RUN: begin
               if (take_s && (in_inc_s == tot_q)) state_d = ST_FLUSH;
               else                               state_d = ST_RUN;
            end
            ST_FLUSH: begin
               if ((hs_s && (out_inc_s == tot_q)) || (fifo_empty_s && overflow_q)) state_d = ST_DONE;
               else                                                               state_d = ST_FLUSH;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Control and address state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         tot_q      <= {CNT_W{1'b0}};
         in_cnt_q   <= {CNT_W{1'b0}};
         out_cnt_q  <= {CNT_W{1'b0}};
         wr_addr_q  <= {ADDR_W{1'b0}};
         overflow_q <= 1'b0;
         excess_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         tot_q      <= tot_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         wr_addr_q  <= wr_addr_d;
         overflow_q <= overflow_d;
         excess_q   <= excess_d;
      end
   end

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (start_ok_s),
      .push_i  (push_s),
      .pop_i   (hs_s),
      .wdata_i (conv_result),
      .rdata_o (fifo_rdata_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .level_o (fifo_level_s)
   );

   assign sram_we    = ~fifo_empty_s;
   assign sram_addr  = wr_addr_q;
   assign sram_wdata = fifo_rdata_s;
   assign busy       = (state_q == ST_RUN) | (state_q == ST_FLUSH);
   assign done       = (state_q == ST_DONE);
   assign overflow   = overflow_q;
   assign excess     = excess_q;
   assign fifo_level = fifo_level_s;

endmodule

// File: tb/tb_ofmap_writer.sv
// Randomised bench for ofmap_writer against a queue-based model of the
// tile/FIFO/SRAM write behaviour.
module tb_ofmap_writer;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] base_addr = 16'd0;
   logic [15:0] total_words = 16'd0;
   logic        conv_valid = 1'b0;
   logic [31:0] conv_result = 32'd0;
   logic        sram_ready = 1'b0;
   logic        sram_we, busy, done, overflow, excess;
   logic [15:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [3:0]  fifo_level;

   always #5 clk = ~clk;

   ofmap_writer dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .total_words(total_words), .conv_valid(conv_valid), .conv_result(conv_result),
      .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_ready(sram_ready), .busy(busy), .done(done), .overflow(overflow),
      .excess(excess), .fifo_level(fifo_level)
   );

   int tests = 0;
   int fails = 0;

   // model state: 0 idle, 1 run, 2 flush, 3 done
   int          m_st, m_in, m_out, m_tot;
   logic [15:0] m_addr;
   bit          m_ovf, m_exc;
   logic [31:0] m_q[$];
   logic [15:0] m_wa[$], d_wa[$];
   logic [31:0] m_wd[$], d_wd[$];
   int          d_done, cyc_bad;

   task automatic model_reset();
      m_st = 0; m_in = 0; m_out = 0; m_tot = 0; m_addr = 16'd0;
      m_ovf = 1'b0; m_exc = 1'b0; m_q.delete();
   endtask

   task automatic clear_logs();
      m_wa.delete(); m_wd.delete(); d_wa.delete(); d_wd.delete();
      d_done = 0; cyc_bad = 0;
   endtask

   function automatic bit logs_ok();
      if (d_wa.size() != m_wa.size()) return 1'b0;
      foreach (d_wa[i]) if (d_wa[i] !== m_wa[i] || d_wd[i] !== m_wd[i]) return 1'b0;
      return 1'b1;
   endfunction

   // One clock cycle: drive, observe DUT at negedge, advance model.
   task automatic step(input bit st, input logic [15:0] base, input int tw,
                       input bit v, input logic [31:0] d, input bit rdy);
      bit hs, room, take, put;
      int nst;
      start = st; base_addr = base; total_words = tw[15:0];
      conv_valid = v; conv_result = d; sram_ready = rdy;
      @(negedge clk);
      if (sram_we && sram_ready) begin
         d_wa.push_back(sram_addr);
         d_wd.push_back(sram_wdata);
      end
      if (done) d_done++;
      if (sram_we !== (m_q.size() != 0) || sram_addr !== m_addr ||
          sram_wdata !== ((m_q.size() != 0) ? m_q[0] : 32'd0) ||
          busy !== (m_st == 1 || m_st == 2) || done !== (m_st == 3) ||
          overflow !== m_ovf || excess !== m_exc || fifo_level !== 4'(m_q.size()))
         cyc_bad++;
      hs   = (m_q.size() != 0) && rdy;
      room = (m_st == 1) && (m_in < m_tot);
      take = v && room;
      put  = take && (m_q.size() < DEPTH || hs);
      nst  = m_st;
      if (m_st == 0 && st) begin
         m_tot = tw; m_addr = base; m_in = 0; m_out = 0;
         m_ovf = 1'b0; m_exc = 1'b0; m_q.delete();
         nst = (tw == 0) ? 3 : 1;
      end else begin
         case (m_st)
            1: if (take && m_in + 1 == m_tot) nst = 2;
            2: if ((hs && m_out + 1 == m_tot) || (m_q.size() == 0 && m_ovf)) nst = 3;
            3: nst = 0;
            default: ;
         endcase
         if (v && !room) m_exc = 1'b1;
         if (take && !put) m_ovf = 1'b1;
         if (hs) begin
            m_wa.push_back(m_addr);
            m_wd.push_back(m_q.pop_front());
            m_addr++; m_out++;
         end
         if (put) m_q.push_back(d);
         if (take) m_in++;
      end
      m_st = nst;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; model_reset(); clear_logs();
      #12;
      tests++; if (sram_we !== 1'b0)  begin fails++; $display("FAIL reset_we: got %b want 0", sram_we); end
      tests++; if (sram_addr !== 16'd0) begin fails++; $display("FAIL reset_addr: got %h want 0000", sram_addr); end
      tests++; if (sram_wdata !== 32'd0) begin fails++; $display("FAIL reset_wdata: got %h want 0", sram_wdata); end
      tests++; if ({busy, done, overflow, excess} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b want 0000", {busy, done, overflow, excess}); end
      tests++; if (fifo_level !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      @(posedge clk); #1; rst = 1'b1;
      repeat (2) step(0, 16'd0, 0, 0, 32'd0, 1);
   endtask

   task automatic test_basic();
      logic [31:0] w[4] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
      clear_logs();
      step(1, 16'h0100, 4, 0, 32'd0, 1);
      for (int i = 0; i < 4; i++) step(0, 16'd0, 0, 1, w[i], 1);
      repeat (5) step(0, 16'd0, 0, 0, 32'd0, 1);
      tests++; if (d_wa.size() != 4) begin fails++; $display("FAIL basic_count: got %0d want 4", d_wa.size()); end
      for (int i = 0; i < 4 && i < d_wa.size(); i++) begin
         tests++; if (d_wa[i] !== 16'h0100 + 16'(i) || d_wd[i] !== w[i]) begin
            fails++; $display("FAIL basic_write%0d: got %h/%h want %h/%h", i, d_wa[i], d_wd[i], 16'h0100 + 16'(i), w[i]);
         end
      end
      tests++; if (d_done != 1) begin fails++; $display("FAIL basic_done: got %0d pulses want 1", d_done); end
      tests++; if (overflow !== 1'b0 || excess !== 1'b0) begin fails++; $display("FAIL basic_flags: got %b%b want 00", overflow, excess); end
      tests++; if (cyc_bad != 0) begin fails++; $display("FAIL basic_cycles: got %0d bad cycles want 0", cyc_bad); end
   endtask

   task automatic test_back_pressure();
      logic [15:0] base = 16'($urandom);
      logic [31:0] w[8];
      logic [15:0] a_mid;
      logic [31:0] d_mid;
      foreach (w[i]) w[i] = $urandom;
      clear_logs();
      step(1, base, 8, 0, 32'd0, 0);
      for (int i = 0; i < 20; i++) begin
         step(0, 16'd0, 0, (i < 8), (i < 8) ? w[i] : 32'd0, 0);
         if (i == 9) begin a_mid = sram_addr; d_mid = sram_wdata; end
      end
      tests++; if (fifo_level !== 4'd8) begin fails++; $display("FAIL bp_level: got %0d want 8", fifo_level); end
      tests++; if (sram_addr !== base || a_mid !== base) begin fails++; $display("FAIL bp_addr_hold: got %h/%h want %h", a_mid, sram_addr, base); end
      tests++; if (sram_wdata !== w[0] || d_mid !== w[0]) begin fails++; $display("FAIL bp_data_hold: got %h/%h want %h", d_mid, sram_wdata, w[0]); end
      repeat (12) step(0, 16'd0, 0, 0, 32'd0, 1);
      tests++; if (d_wa.size() != 8) begin fails++; $display("FAIL bp_count: got %0d want 8", d_wa.size()); end
      for (int i = 0; i < 8 && i < d_wa.size(); i++) begin
         tests++; if (d_wa[i] !== base + 16'(i) || d_wd[i] !== w[i]) begin
            fails++; $display("FAIL bp_write%0d: got %h/%h want %h/%h", i, d_wa[i], d_wd[i], base + 16'(i), w[i]);
         end
      end
      tests++; if (d_done != 1 || overflow !== 1'b0) begin fails++; $display("FAIL bp_end: got done=%0d ovf=%b want 1/0", d_done, overflow); end
      tests++; if (cyc_bad != 0) begin fails++; $display("FAIL bp_cycles: got %0d bad cycles want 0", cyc_bad); end
   endtask

   task automatic test_overflow();
      logic [15:0] base = 16'($urandom);
      logic [31:0] w[10];
      foreach (w[i]) w[i] = $urandom;
      clear_logs();
      step(1, base, 10, 0, 32'd0, 0);
      for (int i = 0; i < 10; i++) step(0, 16'd0, 0, 1, w[i], 0);
      repeat (3) step(0, 16'd0, 0, 0, 32'd0, 0);
      tests++; if (overflow !== 1'b1 || fifo_level !== 4'd8) begin fails++; $display("FAIL ovf_flag: got ovf=%b lvl=%0d want 1/8", overflow, fifo_level); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ovf_wait: got busy=%b want 1", busy); end
      repeat (14) step(0, 16'd0, 0, 0, 32'd0, 1);
      tests++; if (d_wa.size() != 8) begin fails++; $display("FAIL ovf_count: got %0d want 8", d_wa.size()); end
      for (int i = 0; i < 8 && i < d_wa.size(); i++) begin
         tests++; if (d_wa[i] !== base + 16'(i) || d_wd[i] !== w[i]) begin
            fails++; $display("FAIL ovf_write%0d: got %h/%h want %h/%h", i, d_wa[i], d_wd[i], base + 16'(i), w[i]);
         end
      end
      tests++; if (d_done != 1 || busy !== 1'b0) begin fails++; $display("FAIL ovf_end: got done=%0d busy=%b want 1/0", d_done, busy); end
      tests++; if (cyc_bad != 0) begin fails++; $display("FAIL ovf_cycles: got %0d bad cycles want 0", cyc_bad); end
   endtask

   task automatic test_excess();
      logic [15:0] base = 16'($urandom);
      clear_logs();
      repeat (2) step(0, 16'd0, 0, 1, $urandom, 1);
      tests++; if (excess !== 1'b1 || d_wa.size() != 0) begin fails++; $display("FAIL exc_idle: got exc=%b writes=%0d want 1/0", excess, d_wa.size()); end
      step(1, base, 4, 0, 32'd0, 1);
      tests++; if (excess !== 1'b0) begin fails++; $display("FAIL exc_clear: got %b want 0", excess); end
      for (int i = 0; i < 2; i++) step(0, 16'd0, 0, 1, $urandom, 1);
      step(1, base + 16'h0040, 9, 0, 32'd0, 1);
      for (int i = 0; i < 3; i++) step(0, 16'd0, 0, 1, $urandom, 1);
      repeat (6) step(0, 16'd0, 0, 0, 32'd0, 1);
      tests++; if (d_wa.size() != 4) begin fails++; $display("FAIL exc_count: got %0d want 4", d_wa.size()); end
      for (int i = 0; i < 4 && i < d_wa.size(); i++) begin
         tests++; if (d_wa[i] !== base + 16'(i)) begin fails++; $display("FAIL exc_addr%0d: got %h want %h", i, d_wa[i], base + 16'(i)); end
      end
      tests++; if (excess !== 1'b1 || d_done != 1) begin fails++; $display("FAIL exc_end: got exc=%b done=%0d want 1/1", excess, d_done); end
      tests++; if (!logs_ok() || cyc_bad != 0) begin fails++; $display("FAIL exc_model: got %0d bad cycles want 0", cyc_bad); end
   endtask

   task automatic test_zero_words();
      clear_logs();
      step(1, 16'($urandom), 0, 0, 32'd0, 1);
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b want 1", done); end
      repeat (3) step(0, 16'd0, 0, 0, 32'd0, 1);
      tests++; if (d_wa.size() != 0 || d_done != 1 || done !== 1'b0) begin
         fails++; $display("FAIL zero_end: got writes=%0d pulses=%0d done=%b want 0/1/0", d_wa.size(), d_done, done);
      end
   endtask

   task automatic test_addr_wrap();
      logic [15:0] exp_a[3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
      clear_logs();
      step(1, 16'hFFFE, 3, 0, 32'd0, 1);
      for (int i = 0; i < 3; i++) step(0, 16'd0, 0, 1, $urandom, 1'($urandom));
      repeat (40) step(0, 16'd0, 0, 0, 32'd0, 1'($urandom));
      tests++; if (d_wa.size() != 3) begin fails++; $display("FAIL wrap_count: got %0d want 3", d_wa.size()); end
      for (int i = 0; i < 3 && i < d_wa.size(); i++) begin
         tests++; if (d_wa[i] !== exp_a[i]) begin fails++; $display("FAIL wrap_addr%0d: got %h want %h", i, d_wa[i], exp_a[i]); end
      end
      tests++; if (!logs_ok() || cyc_bad != 0 || d_done != 1) begin fails++; $display("FAIL wrap_model: got bad=%0d done=%0d want 0/1", cyc_bad, d_done); end
   endtask

   task automatic test_reset_mid_tile();
      clear_logs();
      step(1, 16'h1234, 6, 0, 32'd0, 0);
      for (int i = 0; i < 3; i++) step(0, 16'd0, 0, 1, $urandom, 0);
      #2 rst = 1'b0;
      #1;
      tests++; if (sram_we !== 1'b0 || sram_addr !== 16'd0 || sram_wdata !== 32'd0) begin
         fails++; $display("FAIL rstmid_sram: got we=%b addr=%h data=%h want 0", sram_we, sram_addr, sram_wdata);
      end
      tests++; if (busy !== 1'b0 || fifo_level !== 4'd0) begin fails++; $display("FAIL rstmid_state: got busy=%b lvl=%0d want 0/0", busy, fifo_level); end
      model_reset();
      @(posedge clk); #1; rst = 1'b1;
      clear_logs();
      step(1, 16'($urandom), 5, 0, 32'd0, 1);
      for (int i = 0; i < 5; i++) step(0, 16'd0, 0, 1, $urandom, 1'($urandom));
      repeat (30) step(0, 16'd0, 0, 0, 32'd0, 1'($urandom));
      tests++; if (d_wa.size() != 5 || d_done != 1) begin fails++; $display("FAIL rstmid_next: got writes=%0d done=%0d want 5/1", d_wa.size(), d_done); end
      tests++; if (!logs_ok() || cyc_bad != 0) begin fails++; $display("FAIL rstmid_model: got %0d bad cycles want 0", cyc_bad); end
   endtask

   task automatic test_random_tiles();
      for (int t = 0; t < 6; t++) begin
         int tw = $urandom_range(1, 12);
         clear_logs();
         step(1, 16'($urandom), tw, 0, 32'd0, 1'($urandom));
         for (int c = 0; c < 80; c++)
            step(0, 16'd0, 0, ($urandom_range(0, 3) != 0) && (c < 40), $urandom, 1'($urandom));
         tests++; if (!logs_ok() || cyc_bad != 0) begin
            fails++; $display("FAIL rand%0d_model: got writes=%0d bad=%0d want writes=%0d bad=0", t, d_wa.size(), cyc_bad, m_wa.size());
         end
         tests++; if (d_done != 1) begin fails++; $display("FAIL rand%0d_done: got %0d want 1", t, d_done); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_pressure();
      test_overflow();
      test_excess();
      test_zero_words();
      test_addr_wrap();
      test_reset_mid_tile();
      test_random_tiles();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ofmap_writer.md
Name: ofmap_writer

Overview:
- Downstream of the partial-sum buffer.
- Takes the 32-bit pooled results (4 x 8-bit ReLU+maxpool bytes) that the buffer emits on its valid pulses, holds them in a small FIFO, and writes them to the output feature-map SRAM at sequential addresses.
- The upstream buffer has no stall input, so this block absorbs SRAM back-pressure and flags any loss.
- A layer controller starts it per output tile and waits for its done pulse.

Parameters:
DATA_W, 32, width of one pooled word (4 packed bytes)
ADDR_W, 16, output SRAM word-address width
FIFO_DEPTH, 8, FIFO entries (power of two)
CNT_W, 16, width of word counters

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a tile (honoured only in IDLE)
base_addr  input  ADDR_W  first SRAM address of the tile; sampled on start
total_words  input  CNT_W  words expected for the tile; sampled on start
conv_valid  input  1  push strobe from the partial-sum buffer
conv_result  input  DATA_W  pooled word; byte0 = lowest output column
sram_we  output  1  write request
sram_addr  output  ADDR_W  write address
sram_wdata  output  DATA_W  write data
sram_ready  input  1  SRAM accepts the write this cycle
busy  output  1  high in RUN and FLUSH
done  output  1  one-cycle pulse when the last word is written
overflow  output  1  sticky; a pushed word was dropped because the FIFO was full
excess  output  1  sticky; a push arrived beyond total_words or outside a tile
fifo_level  output  log2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=0, async): state=IDLE, FIFO empty, counters=0. All outputs 0; sram_addr=0, sram_wdata=0.
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on start with total_words != 0.
  - IDLE -> DONE on start with total_words == 0.
  - RUN -> FLUSH when in_cnt reaches total_words (the accepted push that makes in_cnt == total_words).
  - FLUSH -> DONE on the write handshake that makes out_cnt == total_words.
  - DONE -> IDLE unconditionally after one cycle.
- On start: latch base_addr into wr_addr, latch total_words into tot. Clear in_cnt, out_cnt, FIFO pointers, overflow and excess.
- start while not IDLE: ignored, with no effect on any state.
- Push:
  - A push is accepted when conv_valid=1, state=RUN, in_cnt<tot, and the FIFO is not full or a pop occurs in the same cycle.
  - An accepted push writes conv_result to the tail and increments in_cnt.
  - conv_valid while the FIFO is full with no pop: word dropped, overflow<=1, in_cnt still increments so the tile terminates.
  - conv_valid in IDLE, FLUSH or DONE, or with in_cnt==tot: excess<=1, word dropped.
- Write:
  - sram_we = FIFO non-empty (a function of registers only). sram_wdata = head entry. sram_addr = wr_addr.
  - Handshake = sram_we & sram_ready. It pops the head, increments wr_addr (wraps modulo 2^ADDR_W) and increments out_cnt.
  - sram_we may stay high across cycles with sram_ready low; addr and data must hold stable until the handshake.
- Latency: a word pushed into an empty FIFO appears on sram_wdata with sram_we=1 in the next cycle.
- Simultaneous push and pop:
  - Occupancy unchanged.
  - When full, the push is accepted, not dropped.
  - When empty, no bypass; the push is written and the pop cannot occur.
- Dropped words (overflow) are never written. out_cnt then cannot reach tot.
  - In FLUSH, when the FIFO is empty and overflow=1, go to DONE.
  - Otherwise FLUSH waits for writes.
- done=1 only in DONE. busy=1 in RUN and FLUSH.
- overflow and excess hold until the next accepted start or reset.
- Reset asserted mid-tile: everything returns to reset values immediately; FIFO contents are discarded.

Decomposition:
- Shared package: state encoding constants (IDLE=0, RUN=1, FLUSH=2, DONE=3), DATA_W and ADDR_W defaults shared with the partial-sum buffer and output SRAM wrapper.
- Sub-module sync_fifo: parameterised depth and width, push/pop/full/empty/level, same clock and async active-low reset. Also reusable by the input-fetch side.
- The top module holds the FSM, counters and address generator.

Test Plan:
- Basic tile: start with base_addr=0x0100, total_words=4, sram_ready=1; push 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00 on 4 consecutive cycles -> 4 writes to 0x0100..0x0103 in order, each one cycle after its push; done pulses once, in the cycle after the last write; overflow=0, excess=0.
- Back-pressure: total_words=8, sram_ready=0 for 20 cycles while 8 words are pushed -> fifo_level=8, sram_addr/sram_wdata stable; then sram_ready=1 -> 8 writes to consecutive addresses, done, no overflow.
- Overflow: FIFO_DEPTH=8, sram_ready=0, push 10 words with total_words=10 -> words 9-10 dropped, overflow=1; release ready -> exactly 8 writes, then DONE.
- Excess/idle push: conv_valid in IDLE, and a 5th push with total_words=4 -> excess=1, no extra SRAM write; start mid-RUN -> ignored.
- Edge cases:
  - total_words=0 -> done one cycle after start, no writes.
  - base_addr=0xFFFE, 3 words -> addresses 0xFFFE, 0xFFFF, 0x0000.
  - rst low mid-tile -> all outputs 0 asynchronously; the next tile runs cleanly.
